hdlc_rx_ctrl: RTL

//  Receive-side HDLC frame sequencer, clocked at bit rate alongside flag_detect.

---
 rtl/hdlc_rx_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/hdlc_rx_ctrl.sv
// HDLC receive sequencer: delimits frames using flag_detect, removes zero-bit stuffing,
// assembles LSB-first bytes and reports per-frame status.
module hdlc_rx_ctrl #(
    parameter int unsigned MIN_BYTES = 4,
    parameter int unsigned MAX_BYTES = 2048,
    parameter int unsigned CNT_W     = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data,
    input  logic       flag,
    input  logic       abort,
    input  logic       idle,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_sof,
    output logic       frame_done,
    output logic [1:0] frame_status,
    output logic       overrun,
    output logic       line_idle
);

    localparam int unsigned BIT_W  = 4;
    localparam int unsigned ONES_W = 3;
    localparam int unsigned SKIP_W = 4;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_ABORT    = 2'd1;
    localparam logic [1:0] ST_BADLEN   = 2'd2;
    localparam logic [1:0] ST_OVERLONG = 2'd3;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        OPEN = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [8:0]          sr_q, sr_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]    bytecnt_q, bytecnt_d;
    logic [7:0]          byte_sr_q, byte_sr_d;

    logic [7:0]          rx_byte_d;
    logic                rx_valid_d, rx_sof_d, frame_done_d, overrun_d, line_idle_d;
    logic [1:0]          frame_status_d;

    logic                x, proc_bit, clear_cnt, closing, byte_done;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            sr_q         <= '0;
            skip_q       <= '0;
            ones_q       <= '0;
            bitcnt_q     <= '0;
            bytecnt_q    <= '0;
            byte_sr_q    <= '0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_sof       <= 1'b0;
            frame_done   <= 1'b0;
            frame_status <= ST_OK;
            overrun      <= 1'b0;
            line_idle    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            skip_q       <= skip_d;
            ones_q       <= ones_d;
            bitcnt_q     <= bitcnt_d;
            bytecnt_q    <= bytecnt_d;
            byte_sr_q    <= byte_sr_d;
            rx_byte      <= rx_byte_d;
            rx_valid     <= rx_valid_d;
            rx_sof       <= rx_sof_d;
            frame_done   <= frame_done_d;
            frame_status <= frame_status_d;
            overrun      <= overrun_d;
            line_idle    <= line_idle_d;
        end
    end

    // Next-state, destuffing and byte assembly
    always_comb begin
        state_d        = state_q;
        sr_d           = {sr_q[7:0], data};
        skip_d         = (skip_q != '0) ? skip_q - SKIP_W'(1) : skip_q;
        ones_d         = ones_q;
        bitcnt_d       = bitcnt_q;
        bytecnt_d      = bytecnt_q;
        byte_sr_d      = byte_sr_q;
        rx_byte_d      = rx_byte;
        rx_valid_d     = rx_valid & ~rx_ready;
        rx_sof_d       = rx_sof & ~(rx_valid & rx_ready);
        frame_done_d   = 1'b0;
        frame_status_d = frame_status;
        overrun_d      = overrun;
        line_idle_d    = idle;
        x              = sr_q[8];
        proc_bit       = 1'b0;
        clear_cnt      = 1'b0;
        closing        = 1'b0;
        byte_done      = 1'b0;

        // The flag's own bits drain through sr[8] during the next 8 cycles
        if (flag) begin
            skip_d = SKIP_W'(8);
        end

        case (state_q)
            HUNT: begin
                if (flag) begin
                    state_d = OPEN;
                end
            end
            OPEN: begin
                if (!flag) begin
                    if (abort || idle) begin
                        state_d = HUNT;
                    end else if (skip_q == '0) begin
                        state_d   = DATA;
                        proc_bit  = 1'b1;
                        clear_cnt = 1'b1;
                    end
                end
            end
            DATA: begin
                if (flag) begin
                    proc_bit = (skip_q == '0);
                    closing  = 1'b1;
                    state_d  = OPEN;
                end else if (abort) begin
                    frame_done_d   = 1'b1;
                    frame_status_d = ST_ABORT;
                    state_d        = HUNT;
                end else if (idle) begin
                    state_d = HUNT;
                end else if (skip_q == '0) begin
                    proc_bit = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

        if (clear_cnt) begin
            ones_d    = '0;
            bitcnt_d  = '0;
            bytecnt_d = '0;
            overrun_d = 1'b0;
        end

        if (proc_bit) begin
            if (!x && ones_d == ONES_W'(5)) begin
                ones_d = '0;
            end else begin
                byte_sr_d = {x, byte_sr_d[7:1]};
                if (!x) begin
                    ones_d = '0;
                end else if (ones_d != ONES_W'(6)) begin
                    ones_d = ones_d + ONES_W'(1);
                end
                if (bitcnt_d == BIT_W'(7)) begin
                    byte_done = 1'b1;
                    bitcnt_d  = '0;
                    bytecnt_d = bytecnt_d + CNT_W'(1);
                end else begin
                    bitcnt_d = bitcnt_d + BIT_W'(1);
                end
            end
        end

        // The excess byte of an overlong frame is swallowed, not delivered
        if (byte_done) begin
            if (!closing && bytecnt_d == CNT_W'(MAX_BYTES + 1)) begin
                frame_done_d   = 1'b1;
                frame_status_d = ST_OVERLONG;
                state_d        = HUNT;
            end else if (!rx_valid || rx_ready) begin
                rx_byte_d  = byte_sr_d;
                rx_valid_d = 1'b1;
                rx_sof_d   = (bytecnt_d == CNT_W'(1));
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (closing) begin
            frame_done_d   = 1'b1;
            frame_status_d = (bitcnt_d == '0 && bytecnt_d >= CNT_W'(MIN_BYTES)) ? ST_OK : ST_BADLEN;
        end
    end

endmodule
